// File: rtl/if_npc_btb.sv
// Next-PC generator for the IF stage: direct-mapped BTB with 2-bit counters,
// EX misprediction redirect, and a misprediction counter.
module if_npc_btb #(
   parameter int         IDX_W     = 4,
   parameter logic [1:0] INIT_CTR  = 2'b01,
   parameter logic [1:0] ALLOC_CTR = 2'b10
) (
   input  logic        cpu_clk,
   input  logic        cpu_rstn,
   input  logic [31:0] pc,
   input  logic        if_valid,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic [31:0] npc,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        pred_error,
   output logic        jump_taken,
   output logic [31:0] mispred_cnt
);

   localparam int N     = 1 << IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   logic             r_valid  [N];
   logic [1:0]       r_ctr    [N];
   logic [TAG_W-1:0] r_tag    [N];
   logic [29:0]      r_target [N];
   logic [31:0]      r_mispred_cnt;

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0] w_ex_tag;
   logic             w_hit;
   logic             w_ex_hit;
   logic [N-1:0]     w_ex_sel;
   logic [31:0]      w_pc_plus4;
   logic [31:0]      w_redirect;

   assign w_idx      = pc[IDX_W+1:2];
   assign w_tag      = pc[31:IDX_W+2];
   assign w_ex_idx   = ex_pc[IDX_W+1:2];
   assign w_ex_tag   = ex_pc[31:IDX_W+2];
   assign w_pc_plus4 = pc + 32'd4;

   // Lookup reads pre-update contents; writes become visible next cycle.
   assign w_hit       = if_valid & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign pred_taken  = cpu_rstn & w_hit & r_ctr[w_idx][1];
   assign pred_target = pred_taken ? {r_target[w_idx], 2'b00} : w_pc_plus4;

   assign pred_error = cpu_rstn & ex_valid &
                       ((ex_taken != ex_pred_taken) |
                        (ex_taken & (ex_target != ex_pred_target)));
   assign jump_taken = cpu_rstn & ex_valid & ex_taken & ~pred_error;
   assign w_redirect = ex_taken ? ex_target : (ex_pc + 32'd4);
   assign npc        = pred_error ? w_redirect : pred_target;

   assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_entry
         assign w_ex_sel[gi] = ex_valid & (w_ex_idx == IDX_W'(gi));

         always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
            if (!cpu_rstn) begin
               r_valid[gi] <= 1'b0;
               r_ctr[gi]   <= INIT_CTR;
            end else if (w_ex_sel[gi]) begin
               if (w_ex_hit) begin
                  if (ex_taken && r_ctr[gi] != 2'b11)
                     r_ctr[gi] <= r_ctr[gi] + 2'd1;
                  else if (!ex_taken && r_ctr[gi] != 2'b00)
                     r_ctr[gi] <= r_ctr[gi] - 2'd1;
               end else if (ex_taken) begin
                  r_valid[gi] <= 1'b1;
                  r_ctr[gi]   <= ALLOC_CTR;
               end
            end
         end
      end
   endgenerate

   // Tag/target need no reset: they are only observed behind a valid bit.
   // On a taken hit the tag rewrite is a no-op, so both cases share one write.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rstn && ex_valid && ex_taken) begin
         r_tag[w_ex_idx]    <= w_ex_tag;
         r_target[w_ex_idx] <= ex_target[31:2];
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn)
         r_mispred_cnt <= 32'd0;
      else if (pred_error)
         r_mispred_cnt <= r_mispred_cnt + 32'd1;
   end

   assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_if_npc_btb.sv
// Directed scoreboard bench for if_npc_btb: expected lookup/resolve results are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_if_npc_btb;

   logic        cpu_clk = 1'b0;
   logic        cpu_rstn;
   logic [31:0] pc;
   logic        if_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [31:0] npc;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        pred_error;
   logic        jump_taken;
   logic [31:0] mispred_cnt;

   typedef struct {
      string       tag;
      logic        pt;
      logic [31:0] npc;
      logic        err;
      logic        jt;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] cnt_model = 32'd0;

   if_npc_btb dut (
      .cpu_clk        (cpu_clk),
      .cpu_rstn       (cpu_rstn),
      .pc             (pc),
      .if_valid       (if_valid),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .npc            (npc),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .pred_error     (pred_error),
      .jump_taken     (jump_taken),
      .mispred_cnt    (mispred_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [31:0] p, input logic iv, input logic ev,
                        input logic [31:0] ep, input logic et, input logic [31:0] etg,
                        input logic ept, input logic [31:0] eptg);
      pc = p; if_valid = iv; ex_valid = ev; ex_pc = ep; ex_taken = et;
      ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
   endtask

   task automatic push(input string tag, input logic xpt, input logic [31:0] xnpc,
                       input logic xerr, input logic xjt);
      exp_t e;
      e.tag = tag; e.pt = xpt; e.npc = xnpc; e.err = xerr; e.jt = xjt;
      exp_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      check({e.tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, e.pt});
      check({e.tag, ".npc"},        npc,                  e.npc);
      check({e.tag, ".pred_error"}, {31'd0, pred_error}, {31'd0, e.err});
      check({e.tag, ".jump_taken"}, {31'd0, jump_taken}, {31'd0, e.jt});
      $display("txn %-10s pc=%08h npc=%08h pt=%0d err=%0d jt=%0d cnt=%0d",
               e.tag, pc, npc, pred_taken, pred_error, jump_taken, mispred_cnt);
   endtask

   // One cycle: drive at negedge, sample combinational outputs mid-low-phase,
   // then check the counter just after the rising edge.
   task automatic step(input string tag, input logic [31:0] p, input logic iv, input logic ev,
                       input logic [31:0] ep, input logic et, input logic [31:0] etg,
                       input logic ept, input logic [31:0] eptg,
                       input logic xpt, input logic [31:0] xnpc, input logic xerr, input logic xjt);
      drive(p, iv, ev, ep, et, etg, ept, eptg);
      push(tag, xpt, xnpc, xerr, xjt);
      #2;
      compare_out();
      @(posedge cpu_clk);
      #1;
      if (xerr) cnt_model = cnt_model + 32'd1;
      check({tag, ".cnt"}, mispred_cnt, cnt_model);
      @(negedge cpu_clk);
   endtask

   initial begin
      // Reset with a would-be mispredict on EX: outputs must stay quiet.
      cpu_rstn = 1'b0;
      drive(32'hBFC0_0000, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
      push("reset", 1'b0, 32'hBFC0_0004, 1'b0, 1'b0);
      #2;
      compare_out();
      check("reset.cnt", mispred_cnt, 32'd0);
      @(negedge cpu_clk);
      @(negedge cpu_clk);
      drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      cpu_rstn = 1'b1;

      //   tag           pc            iv ev ex_pc   et ex_tgt        ept ex_ptgt    | pt npc           err jt
      step("alloc",     32'h0,        1, 1, 32'h100, 1, 32'h200,      0, 32'h0,      0, 32'h200,      1, 0);
      step("hit",       32'h100,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      1, 32'h200,      0, 0);
      step("nt1_same",  32'h100,      1, 1, 32'h100, 0, 32'h0,        1, 32'h200,    1, 32'h104,      1, 0);
      step("nt2",       32'h100,      1, 1, 32'h100, 0, 32'h0,        0, 32'h0,      0, 32'h104,      0, 0);
      step("nt3",       32'h100,      1, 1, 32'h100, 0, 32'h0,        0, 32'h0,      0, 32'h104,      0, 0);
      step("sat0",      32'h100,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      0, 32'h104,      0, 0);
      step("up1",       32'h100,      1, 1, 32'h100, 1, 32'h200,      0, 32'h0,      0, 32'h200,      1, 0);
      step("up2",       32'h100,      1, 1, 32'h100, 1, 32'h200,      0, 32'h0,      0, 32'h200,      1, 0);
      step("up3",       32'h100,      1, 1, 32'h100, 1, 32'h200,      1, 32'h200,    1, 32'h200,      0, 1);
      step("up4_sat",   32'h100,      1, 1, 32'h100, 1, 32'h200,      1, 32'h200,    1, 32'h200,      0, 1);
      step("dn_from11", 32'h100,      1, 1, 32'h100, 0, 32'h0,        1, 32'h200,    1, 32'h104,      1, 0);
      step("still_tk",  32'h100,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      1, 32'h200,      0, 0);
      step("alias",     32'h100,      1, 1, 32'h140, 1, 32'h300,      0, 32'h0,      1, 32'h300,      1, 0);
      step("alias_miss",32'h100,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      0, 32'h104,      0, 0);
      step("alias_hit", 32'h140,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      1, 32'h300,      0, 0);
      step("jump_ok",   32'h0,        1, 1, 32'h140, 1, 32'h300,      1, 32'h300,    0, 32'h4,        0, 1);
      step("tgt_err",   32'h0,        1, 1, 32'h140, 1, 32'h303,      1, 32'h300,    0, 32'h303,      1, 0);
      step("misalign",  32'h140,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      1, 32'h300,      0, 0);
      step("ifv0",      32'h140,      0, 0, 32'h0,   0, 32'h0,        0, 32'h0,      0, 32'h144,      0, 0);
      step("wrap",      32'hFFFF_FFFC,1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      0, 32'h0,        0, 0);
      step("nt_miss",   32'h0,        1, 1, 32'h180, 0, 32'h0,        0, 32'h0,      0, 32'h4,        0, 0);
      step("no_alloc",  32'h180,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      0, 32'h184,      0, 0);

      // Asynchronous reset mid-cycle while EX reports a mispredict.
      drive(32'h140, 1'b1, 1'b1, 32'h140, 1'b0, 32'h0, 1'b1, 32'h300);
      #1;
      cpu_rstn = 1'b0;
      push("mid_reset", 1'b0, 32'h144, 1'b0, 1'b0);
      #1;
      compare_out();
      check("mid_reset.cnt", mispred_cnt, 32'd0);
      @(negedge cpu_clk);
      drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      cpu_rstn = 1'b1;
      cnt_model = 32'd0;

      step("post_rst",  32'h140,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      0, 32'h144,      0, 0);
      step("post_rst2", 32'h100,      1, 0, 32'h0,   0, 32'h0,        0, 32'h0,      0, 32'h104,      0, 0);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
